// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: ALU control codes, sequencer state encoding and op-class helper
package alu_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    function automatic logic is_arith(input logic [3:0] c);
        return (c == CTRL_ADD) || (c == CTRL_SUB) || (c == CTRL_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_dp.sv
// alu_serial_dp: operand/result shift registers, carry loop and MSB capture flops
module alu_serial_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             msb_i,
    input  logic             cin_init_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             slice_result_i,
    input  logic             slice_cout_i,
    output logic             a_lsb_o,
    output logic             b_lsb_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] res_o,
    output logic             msb_cin_o,
    output logic             msb_cout_o,
    output logic             msb_sum_o
);

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q, msb_cin_q, msb_cout_q, msb_sum_q;

    // load operands on accept, then shift one bit pair per cycle and collect slice results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            msb_cin_q  <= 1'b0;
            msb_cout_q <= 1'b0;
            msb_sum_q  <= 1'b0;
        end else if (load_i) begin
            a_q     <= src1_i;
            b_q     <= src2_i;
            carry_q <= cin_init_i;
        end else if (shift_i) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            res_q   <= {slice_result_i, res_q[WIDTH-1:1]};
            carry_q <= slice_cout_i;
            if (msb_i) begin
                msb_cin_q  <= carry_q;
                msb_cout_q <= slice_cout_i;
                msb_sum_q  <= slice_result_i;
            end
        end
    end

    assign a_lsb_o    = a_q[0];
    assign b_lsb_o    = b_q[0];
    assign carry_o    = carry_q;
    assign res_o      = res_q;
    assign msb_cin_o  = msb_cin_q;
    assign msb_cout_o = msb_cout_q;
    assign msb_sum_o  = msb_sum_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving a 1-bit slice (ALU_SERIAL_OVF_EN adds overflow_o)
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_ainv_o,
    output logic             slice_binv_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_op_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] result_q, res, fin_result;
    logic             zero_q, load, shift, fin, ovf;
    logic             msb_cin, msb_cout, msb_sum;

    alu_serial_dp #(.WIDTH(WIDTH)) u_dp (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load),
        .shift_i        (shift),
        .msb_i          (cnt_q == LAST),
        .cin_init_i     (ctrl_i[2]),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .slice_result_i (slice_result_i),
        .slice_cout_i   (slice_cout_i),
        .a_lsb_o        (slice_src1_o),
        .b_lsb_o        (slice_src2_o),
        .carry_o        (slice_cin_o),
        .res_o          (res),
        .msb_cin_o      (msb_cin),
        .msb_cout_o     (msb_cout),
        .msb_sum_o      (msb_sum)
    );

    // next-state, counter and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                load    = start_i;
                state_d = start_i ? S_RUN : S_IDLE;
                cnt_d   = '0;
            end
            S_RUN: begin
                shift   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? S_FINISH : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fin        = state_q == S_FINISH;
    assign ovf        = is_arith(ctrl_q) & (msb_cin ^ msb_cout);
    assign fin_result = (ctrl_q == CTRL_SLT) ? {{(WIDTH-1){1'b0}}, msb_sum ^ ovf} : res;

    assign busy_o       = state_q != S_IDLE;
    assign done_o       = fin;
    assign result_o     = fin ? fin_result : result_q;
    assign zero_o       = fin ? (fin_result == '0) : zero_q;
    assign slice_less_o = 1'b0;
    assign slice_ainv_o = ctrl_q[3];
    assign slice_binv_o = ctrl_q[2];
    assign slice_op_o   = (ctrl_q == CTRL_SLT) ? 2'b10 : ctrl_q[1:0];

    // state, counter, captured control and held result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) ctrl_q <= ctrl_i;
            if (fin) begin
                result_q <= fin_result;
                zero_q   <= fin_result == '0;
            end
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_q;

    // overflow flag held alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (fin) ovf_q <= ovf;
    end

    assign overflow_o = fin ? ovf : ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed bench for alu_serial_ctrl with a behavioural 1-bit slice
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  ctrl_i = '0;
    logic [31:0] src1_i = '0, src2_i = '0;
    logic        busy_o, done_o, zero_o;
    logic [31:0] result_o;
    logic        s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_res, s_cout, sa, sb;
    logic [1:0]  s_op;
    logic        ovf_obs;
    int          n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .ctrl_i         (ctrl_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_o       (result_o),
        .zero_o         (zero_o),
        .slice_src1_o   (s_src1),
        .slice_src2_o   (s_src2),
        .slice_less_o   (s_less),
        .slice_ainv_o   (s_ainv),
        .slice_binv_o   (s_binv),
        .slice_cin_o    (s_cin),
        .slice_op_o     (s_op),
        .slice_result_i (s_res),
        .slice_cout_i   (s_cout)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .overflow_o     (ovf_obs)
`endif
    );

`ifndef ALU_SERIAL_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    // 1-bit ALU slice: optional inversion, AND/OR/sum/less select, full-adder carry
    assign sa     = s_ainv ? ~s_src1 : s_src1;
    assign sb     = s_binv ? ~s_src2 : s_src2;
    assign s_res  = (s_op == 2'b00) ? (sa & sb) : (s_op == 2'b01) ? (sa | sb) :
                    (s_op == 2'b10) ? (sa ^ sb ^ s_cin) : s_less;
    assign s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);

    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic o,
                         output int lat, output logic d2, output logic [31:0] r2);
        @(negedge clk);
        start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        lat = -1; r = 'x; z = 1'bx; o = 1'bx;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = e; r = result_o; z = zero_o; o = ovf_obs;
                break;
            end
        end
        @(posedge clk); #1;
        d2 = done_o; r2 = result_o;
    endtask

    task automatic test_reset;
        #1;
        n_assert++; if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_assert++; if (done_o !== 1'b0)       begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_assert++; if (result_o !== 32'h0)    begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
        n_assert++; if (zero_o !== 1'b0)       begin n_fail++; $display("FAIL reset_zero got=%b exp=0", zero_o); end
        n_assert++; if (s_cin !== 1'b0)        begin n_fail++; $display("FAIL reset_cin got=%b exp=0", s_cin); end
        n_assert++; if (ovf_obs !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_obs); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_ops;
        logic [3:0]  tc[8] = '{4'b0010, 4'b0110, 4'b0010, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 4'b1100};
        logic [31:0] ta[8] = '{32'd5, 32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0};
        logic [31:0] tb[8] = '{32'd7, 32'd3, 32'h1, 32'h1, 32'h80000000, 32'hFF00FF00, 32'hFF00FF00, 32'h0};
        logic [31:0] tr[8] = '{32'hC, 32'h0, 32'h80000000, 32'h1, 32'h0, 32'hF000F000, 32'hFFF0FFF0, 32'hFFFFFFFF};
        logic        tz[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        to[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] r, r2;
        logic        z, o, d2;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            do_op(tc[i], ta[i], tb[i], r, z, o, lat, d2, r2);
            n_assert++; if (lat !== 32)   begin n_fail++; $display("FAIL op%0d_latency got_cycle=%0d exp_cycle=33", i, lat + 1); end
            n_assert++; if (r !== tr[i])  begin n_fail++; $display("FAIL op%0d_result got=%h exp=%h", i, r, tr[i]); end
            n_assert++; if (z !== tz[i])  begin n_fail++; $display("FAIL op%0d_zero got=%b exp=%b", i, z, tz[i]); end
            n_assert++; if (d2 !== 1'b0)  begin n_fail++; $display("FAIL op%0d_done_pulse got=%b exp=0", i, d2); end
            n_assert++; if (r2 !== tr[i]) begin n_fail++; $display("FAIL op%0d_hold got=%h exp=%h", i, r2, tr[i]); end
`ifdef ALU_SERIAL_OVF_EN
            n_assert++; if (o !== to[i])  begin n_fail++; $display("FAIL op%0d_ovf got=%b exp=%b", i, o, to[i]); end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int          ndone = 0, lat = -1;
        logic [31:0] r = '0;
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd7;
        @(posedge clk);
        for (int e = 1; e <= 33; e++) begin
            @(negedge clk);
            start_i = (e == 5) || (e == 33);
            src1_i = 32'd100; src2_i = 32'd100;
            @(posedge clk); #1;
            if (done_o) begin
                ndone++;
                r = result_o;
                n_assert++; if (e !== 32) begin n_fail++; $display("FAIL ign_done_cycle got=%0d exp=33", e + 1); end
            end
            if (e == 33) begin
                n_assert++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_finish_start got_busy=%b exp=0", busy_o); end
            end
        end
        n_assert++; if (ndone !== 1)  begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        n_assert++; if (r !== 32'hC)  begin n_fail++; $display("FAIL ign_result got=%h exp=0000000c", r); end
        @(negedge clk);
        start_i = 1'b1; src1_i = 32'd2; src2_i = 32'd3;
        @(posedge clk); #1;
        n_assert++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ign_accept34 got_busy=%b exp=1", busy_o); end
        @(negedge clk); start_i = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (done_o) begin lat = e; r = result_o; break; end
        end
        n_assert++; if (lat !== 32)  begin n_fail++; $display("FAIL ign_second_latency got=%0d exp=32", lat); end
        n_assert++; if (r !== 32'd5) begin n_fail++; $display("FAIL ign_second_result got=%h exp=00000005", r); end
        @(posedge clk);
    endtask

    task automatic test_mid_reset;
        logic [31:0] r, r2;
        logic        z, o, d2, seen = 1'b0;
        int          lat;
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 4'b0110; src1_i = 32'd9; src2_i = 32'd4;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_assert++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy_o); end
        n_assert++; if (done_o !== 1'b0)    begin n_fail++; $display("FAIL mrst_done got=%b exp=0", done_o); end
        n_assert++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL mrst_result got=%h exp=0", result_o); end
        n_assert++; if (zero_o !== 1'b0)    begin n_fail++; $display("FAIL mrst_zero got=%b exp=0", zero_o); end
        repeat (3) begin @(posedge clk); #1; seen |= done_o; end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; seen |= done_o; end
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mrst_no_done got=%b exp=0", seen); end
        do_op(4'b0010, 32'd1, 32'd1, r, z, o, lat, d2, r2);
        n_assert++; if (lat !== 32)  begin n_fail++; $display("FAIL mrst_latency got=%0d exp=32", lat); end
        n_assert++; if (r !== 32'd2) begin n_fail++; $display("FAIL mrst_result_after got=%h exp=00000002", r); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_ignore_start();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
